// File: rtl/fluxo_dados_drone.sv
// Datapath for the drone game.
// Holds the wait timer, the map scroll index and the drone row.
// Reports end-of-wait, end-of-map and collision to the control unit.
// Also builds the 4x4 obstacle window shown on the display.

// One display column: obstacle cell of map column pos+COL, empty past the map end
module fluxo_dados_drone_coluna #(
   parameter int COL = 0
) (
   input  logic [15:0][2:0] mapa,
   input  logic [3:0]       pos,
   output logic [3:0]       celulas
);
   logic [4:0] k;
   logic [2:0] ent;

   // Carry into bit 4 means the column lies beyond the last map entry (no wrap)
   assign k   = {1'b0, pos} + 5'(COL);
   assign ent = mapa[k[3:0]];

   // Light the obstacle row of this column, if any
   always_comb begin
      celulas = '0;
      if (!k[4] && ent[2])
         celulas[ent[1:0]] = 1'b1;
   end
endmodule

module fluxo_dados_drone #(
   parameter logic [31:0] ESPERA = 32'd50_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        zeraPosicoes,
   input  logic        contaT,
   input  logic        zeraT,
   input  logic        desloca,
   input  logic        subir,
   input  logic        descer,
   output logic        fim_espera,
   output logic        fim_mapa,
   output logic        colisao,
   output logic [15:0] tela,
   output logic [1:0]  db_linha,
   output logic [3:0]  db_posicao
);
   localparam int          NUM_COLS = 4;
   localparam logic [31:0] LIMITE   = ESPERA - 32'd1;

   // Map ROM, entry = {has, row[1:0]}, listed from column 15 down to column 0.
   // Obstacles zig-zag through rows 0,1,2,3,2,1,0 on the even columns 2..14.
   localparam logic [15:0][2:0] MAPA = {
      3'b000, 3'b100, 3'b000, 3'b101,   // 15..12
      3'b000, 3'b110, 3'b000, 3'b111,   // 11..8
      3'b000, 3'b110, 3'b000, 3'b101,   // 7..4
      3'b000, 3'b100, 3'b000, 3'b000    // 3..0
   };

   logic [3:0]  pos;
   logic [1:0]  linha;
   logic        prev_subir;
   logic        prev_descer;
   logic [31:0] cnt;
   logic        borda_subir;
   logic        borda_descer;
   logic [2:0]  ent_atual;
   logic [NUM_COLS-1:0][3:0] tela_cols;

   assign borda_subir  = subir  & ~prev_subir;
   assign borda_descer = descer & ~prev_descer;

   // Map index: clear wins over shift, saturates on the last column
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         pos <= 4'd0;
      else if (zeraPosicoes)
         pos <= 4'd0;
      else if (desloca && pos != 4'd15)
         pos <= pos + 4'd1;
   end

   // Button edge registers; reset to 0 so a button held through reset counts once
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_subir  <= 1'b0;
         prev_descer <= 1'b0;
      end else begin
         prev_subir  <= subir;
         prev_descer <= descer;
      end
   end

   // Drone row: starts in row 1, moves one row per isolated button edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         linha <= 2'd1;
      else if (zeraPosicoes)
         linha <= 2'd1;
      else if (borda_subir && !borda_descer && linha != 2'd0)
         linha <= linha - 2'd1;
      else if (borda_descer && !borda_subir && linha != 2'd3)
         linha <= linha + 2'd1;
   end

   // Wait timer: counts up to ESPERA-1 and parks there until cleared
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cnt <= 32'd0;
      else if (zeraT)
         cnt <= 32'd0;
      else if (contaT && cnt < LIMITE)
         cnt <= cnt + 32'd1;
   end

   assign fim_espera = (cnt == LIMITE);
   assign fim_mapa   = (pos == 4'd15);

   // The drone always sits in display column 0, i.e. map column pos
   assign ent_atual = MAPA[pos];
   assign colisao   = ent_atual[2] & (ent_atual[1:0] == linha);

   // Visible window: columns pos..pos+3
   genvar c;
   generate
      for (c = 0; c < NUM_COLS; c++) begin : g_col
         fluxo_dados_drone_coluna #(.COL(c)) u_col (
            .mapa    (MAPA),
            .pos     (pos),
            .celulas (tela_cols[c])
         );
      end
   endgenerate

   assign tela       = tela_cols;
   assign db_linha   = linha;
   assign db_posicao = pos;
endmodule

// File: tb/tb_fluxo_dados_drone.sv
// Scoreboard bench for fluxo_dados_drone with ESPERA=4.
module tb_fluxo_dados_drone;
   localparam logic [31:0] ESPERA = 32'd4;

   localparam int S_TELA  = 0;
   localparam int S_POS   = 1;
   localparam int S_LINHA = 2;
   localparam int S_COL   = 3;
   localparam int S_FIMM  = 4;
   localparam int S_FIMT  = 5;
   localparam int S_CNT   = 6;

   typedef struct {
      string       nome;
      int          sel;
      logic [31:0] val;
   } esp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        zeraPosicoes = 1'b0;
   logic        contaT = 1'b0;
   logic        zeraT = 1'b0;
   logic        desloca = 1'b0;
   logic        subir = 1'b0;
   logic        descer = 1'b0;
   logic        fim_espera;
   logic        fim_mapa;
   logic        colisao;
   logic [15:0] tela;
   logic [1:0]  db_linha;
   logic [3:0]  db_posicao;

   esp_t fila[$];
   int   compared = 0;
   int   mismatched = 0;
   event smp;

   fluxo_dados_drone #(.ESPERA(ESPERA)) dut (
      .clock        (clock),
      .reset        (reset),
      .zeraPosicoes (zeraPosicoes),
      .contaT       (contaT),
      .zeraT        (zeraT),
      .desloca      (desloca),
      .subir        (subir),
      .descer       (descer),
      .fim_espera   (fim_espera),
      .fim_mapa     (fim_mapa),
      .colisao      (colisao),
      .tela         (tela),
      .db_linha     (db_linha),
      .db_posicao   (db_posicao)
   );

   always #5 clock = ~clock;

   // Monitor: drain the expectation queue on each falling edge or explicit sample request
   initial begin
      esp_t        e;
      logic [31:0] act;
      forever begin
         @(negedge clock or smp);
         while (fila.size() > 0) begin
            e = fila.pop_front();
            case (e.sel)
               S_TELA:  act = {16'd0, tela};
               S_POS:   act = {28'd0, db_posicao};
               S_LINHA: act = {30'd0, db_linha};
               S_COL:   act = {31'd0, colisao};
               S_FIMM:  act = {31'd0, fim_mapa};
               S_FIMT:  act = {31'd0, fim_espera};
               default: act = dut.cnt;
            endcase
            compared++;
            if (act !== e.val) begin
               mismatched++;
               $display("FAIL %s: got %0h, expected %0h", e.nome, act, e.val);
            end
         end
      end
   end

   task automatic esp(input string n, input int s, input logic [31:0] v);
      esp_t e;
      e.nome = n;
      e.sel  = s;
      e.val  = v;
      fila.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] lin_esp[5];
      lin_esp[0] = 2'd1; lin_esp[1] = 2'd2; lin_esp[2] = 2'd3;
      lin_esp[3] = 2'd3; lin_esp[4] = 2'd3;

      // Reset state
      cyc(); cyc();
      esp("rst_pos", S_POS, 0);
      esp("rst_linha", S_LINHA, 1);
      esp("rst_tela", S_TELA, 32'h0100);
      esp("rst_col", S_COL, 0);
      esp("rst_fimm", S_FIMM, 0);
      esp("rst_fimt", S_FIMT, 0);
      cyc();
      reset = 1'b0;
      cyc();

      // Timer: fim_espera after 3 counts, then holds; zeraT beats contaT
      zeraT = 1'b1; cyc();
      zeraT = 1'b0; contaT = 1'b1;
      cyc(); esp("tmr_c1", S_FIMT, 0);
      cyc(); esp("tmr_c2", S_FIMT, 0);
      cyc(); esp("tmr_c3", S_FIMT, 1); esp("tmr_cnt3", S_CNT, 3);
      cyc(); esp("tmr_hold", S_FIMT, 1); esp("tmr_cnt_hold", S_CNT, 3);
      zeraT = 1'b1;
      cyc(); esp("tmr_clr_cnt", S_CNT, 0); esp("tmr_clr_fim", S_FIMT, 0);
      zeraT = 1'b0; contaT = 1'b0;

      // Collision at column 2 row 0
      subir = 1'b1;
      cyc(); esp("col_up", S_LINHA, 0);
      subir = 1'b0; desloca = 1'b1;
      cyc(); cyc();
      desloca = 1'b0;
      esp("col_pos2", S_POS, 2);
      esp("col_hit", S_COL, 1);
      esp("col_tela2", S_TELA, 32'h0201);
      desloca = 1'b1;
      cyc();
      desloca = 1'b0;
      esp("col_pos3", S_POS, 3);
      esp("col_miss", S_COL, 0);
      esp("col_tela3", S_TELA, 32'h4020);

      // Saturation and edge detection
      zeraPosicoes = 1'b1;
      cyc();
      zeraPosicoes = 1'b0;
      esp("sat_clr_pos", S_POS, 0);
      esp("sat_clr_lin", S_LINHA, 1);
      subir = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(); esp($sformatf("sat_hold%0d", i), S_LINHA, 0);
      end
      subir = 1'b0;
      cyc();
      for (int i = 0; i < 5; i++) begin
         descer = 1'b1; cyc();
         descer = 1'b0; cyc();
         esp($sformatf("sat_down%0d", i), S_LINHA, 32'(lin_esp[i]));
      end
      subir = 1'b1; cyc();
      subir = 1'b0; cyc();
      esp("sat_up_to2", S_LINHA, 2);
      subir = 1'b1; descer = 1'b1;
      cyc(); esp("sat_both", S_LINHA, 2);
      cyc(); esp("sat_both_held", S_LINHA, 2);
      subir = 1'b0; descer = 1'b0;
      cyc();

      // Map end
      zeraPosicoes = 1'b1; cyc(); zeraPosicoes = 1'b0;
      desloca = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (i == 12) begin
            esp("map_pos13", S_POS, 13);
            esp("map_tela13", S_TELA, 32'h0010);
         end
         if (i == 13) esp("map_fimm14", S_FIMM, 0);
      end
      desloca = 1'b0;
      esp("map_pos_sat", S_POS, 15);
      esp("map_fimm", S_FIMM, 1);
      esp("map_tela15", S_TELA, 32'h0000);
      cyc();

      // Clear beats shift and move
      zeraPosicoes = 1'b1; desloca = 1'b1; descer = 1'b1;
      cyc();
      zeraPosicoes = 1'b0; desloca = 1'b0; descer = 1'b0;
      esp("pri_pos", S_POS, 0);
      esp("pri_linha", S_LINHA, 1);
      esp("pri_fimm", S_FIMM, 0);
      cyc();

      // Async reset mid-count
      desloca = 1'b1; descer = 1'b1; cyc();
      desloca = 1'b0; descer = 1'b0;
      zeraT = 1'b1; cyc();
      zeraT = 1'b0; contaT = 1'b1;
      cyc(); cyc();
      esp("ar_cnt2", S_CNT, 2);
      esp("ar_pos1", S_POS, 1);
      esp("ar_lin2", S_LINHA, 2);
      @(negedge clock);
      #1;
      reset = 1'b1;
      #1;
      esp("ar_cnt0", S_CNT, 0);
      esp("ar_pos0", S_POS, 0);
      esp("ar_lin1", S_LINHA, 1);
      esp("ar_fimt", S_FIMT, 0);
      ->smp;
      #1;
      contaT = 1'b0;
      cyc();
      reset = 1'b0;
      cyc(); cyc();

      compared++;
      if (fila.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending, expected 0", fila.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/fluxo_dados_drone.md
# fluxo_dados_drone

Datapath for the drone game. Executes the control unit's commands: wait timer, map scrolling, player drone position. Returns `fim_espera`, `fim_mapa` and `colisao` to the control unit. Also drives the display grid and debug outputs.

## Interface

Parameters:
- `ESPERA`, default 50_000_000: wait-timer length in clock cycles per map step. Legal range is 1..2^32-1.

Ports (name, direction, width, meaning):
- `clock`, in, 1: system clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `zeraPosicoes`, in, 1: sync clear of map index and drone row.
- `contaT`, in, 1: timer count enable.
- `zeraT`, in, 1: sync timer clear.
- `desloca`, in, 1: advance map by one column.
- `subir`, in, 1: player "up" button, level; a rising edge moves the drone.
- `descer`, in, 1: player "down" button, level; a rising edge moves the drone.
- `fim_espera`, out, 1: timer reached `ESPERA-1`.
- `fim_mapa`, out, 1: map index is on the last column.
- `colisao`, out, 1: the drone occupies an obstacle cell.
- `tela`, out, 16: obstacle grid of the visible window. Bit `c*4+r` is column `c` (0..3, 0 = drone column) and row `r` (0..3).
- `db_linha`, out, 2: drone row.
- `db_posicao`, out, 4: map index.

## Operation

Map:
- The map is a fixed 16-column combinational ROM. Each entry is {has, row[1:0]}.
- Obstacles sit at column 2 → row 0, 4 → 1, 6 → 2, 8 → 3, 10 → 2, 12 → 1, 14 → 0.
- All other columns (0, odd, 15) are empty.
- Row 0 is the top row.

Map index `pos` (4 bits):
- Reset sets it to 0; `zeraPosicoes` clears it to 0.
- `desloca` increments it, saturating at 15.
- `zeraPosicoes` has priority over `desloca`.
- `fim_mapa = (pos == 15)`.

Drone row `linha` (2 bits):
- Reset and `zeraPosicoes` both set it to 1.
- A rising edge of `subir` decrements it, saturating at 0.
- A rising edge of `descer` increments it, saturating at 3.
- Rising edges on both in the same cycle: no move.
- `zeraPosicoes` has priority over any move.
- Edge detection uses one register per button, `prev <= button`. A move happens when `button & ~prev`.
- The edge registers reset to 0, so a button held high through reset moves the drone once after reset is released.

Collision:
- `colisao = has[pos] & (row[pos] == linha)`. Combinational; no latching.

Timer `cnt` (32 bits):
- Reset sets it to 0; `zeraT` clears it to 0 and has priority over `contaT`.
- `contaT` increments it when `cnt < ESPERA-1`; it holds at `ESPERA-1` otherwise.
- `fim_espera = (cnt == ESPERA-1)`. Combinational from the register.

Display `tela`:
- For `c` = 0..3, let `k = pos + c`.
- If `k <= 15` and `has[k]`, bit `c*4+row[k]` is 1.
- All other bits are 0; columns past the map end are empty, with no wrap-around.

## Timing

- All state is updated on the rising `clock` edge. All status outputs and `tela` are combinational from registers.
- Reset values: `pos=0`, `linha=1`, `cnt=0`. This gives `fim_mapa=0`, `colisao=0`, `fim_espera=(ESPERA==1)`, `tela=16'h0100`, `db_linha=1`, `db_posicao=0`.
- `desloca` latency: `pos` and `colisao` reflect the new column one cycle after `desloca` is high. This matches the control unit sampling `colisao` in the state after the shift.
- Wait length: with `zeraT` then `contaT` held high, `fim_espera` rises after `ESPERA-1` counting cycles. The control unit's `espera` state therefore lasts `ESPERA` cycles, including the exit cycle.
- Button to row latency: one cycle from the first cycle the button is high to `linha` updating.
- Asserting reset mid-game clears all state immediately and asynchronously, regardless of other inputs.

## Test plan

- **Reset:** set `ESPERA=4` and pulse reset. Expect `db_posicao=0`, `db_linha=1`, `tela=0x0100`, `colisao=0`, `fim_mapa=0`, `fim_espera=0`.
- **Timer:** `zeraT` for 1 cycle, then `contaT` high. Expect `fim_espera=1` after 3 count cycles and holding. Assert `zeraT` together with `contaT`: expect `cnt=0` and `fim_espera=0` the next cycle.
- **Collision:** from reset, press `subir` once (`linha=0`), then 2× `desloca`. Expect `pos=2`, `colisao=1`. One more `desloca`: expect `pos=3`, `colisao=0`.
- **Saturation:** hold `subir` high for 10 cycles. Expect a single move, 1 → 0. Then 5 separate `descer` pulses: expect `linha` to go 1, 2, 3, 3, 3. Both buttons rising in the same cycle: expect `linha` unchanged.
- **Map end:** 20× `desloca`. Expect `pos` saturated at 15, `fim_mapa=1`, `tela=0x0000`. At `pos=13` expect `tela` bit 4 set (column 14 row 0, `c=1`) and all other bits 0.
- **Priority and reset:** `zeraPosicoes` with `desloca` and a `descer` edge in the same cycle: expect `pos=0`, `linha=1`. Async reset asserted mid-count with `cnt=2`: expect `cnt=0` immediately, with no clock edge needed.
